// File: rtl/adc_mean_reference.sv
// Idle-link reference level: after a blind settle period, averages the
// folded ADC peak of 2^LOG2_NWIN consecutive windows and holds the result.
module adc_mean_reference #(
  parameter int              ADC_W        = 12,
  parameter logic [ADC_W-1:0] MID         = 12'h800,
  parameter int              BLIND_CYCLES = 500000,
  parameter int              WIN_CYCLES   = 40000,
  parameter int              LOG2_NWIN    = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             swiptAlive,
  input  logic             start,
  input  logic [ADC_W-1:0] ADC,
  output logic [ADC_W-1:0] mean_def,
  output logic             mean_valid,
  output logic             busy
);

  localparam int NWIN = 1 << LOG2_NWIN;
  localparam int AW   = ADC_W + LOG2_NWIN;
  localparam int BW   = $clog2(BLIND_CYCLES + 1);
  localparam int WW   = $clog2(WIN_CYCLES + 1);
  localparam int LW   = LOG2_NWIN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLIND,
    S_ACCUM,
    S_UPDATE
  } state_t;

  state_t           r_state, w_state;
  logic [BW-1:0]    r_blind, w_blind;
  logic [WW-1:0]    r_win, w_win;
  logic [LW-1:0]    r_idx, w_idx;
  logic [ADC_W-1:0] r_peak, w_peak;
  logic [AW-1:0]    r_acc, w_acc;
  logic [ADC_W-1:0] r_mean, w_mean;
  logic             r_valid, w_valid;

  logic [ADC_W-1:0] w_fold;
  logic [ADC_W-1:0] w_pk;

  // Fold around midscale so both swing polarities give a peak distance.
  assign w_fold = (ADC < MID) ? ADC : ~ADC;
  assign w_pk   = (w_fold > r_peak) ? w_fold : r_peak;

  always_comb begin
    w_state = r_state;
    w_blind = r_blind;
    w_win   = r_win;
    w_idx   = r_idx;
    w_peak  = r_peak;
    w_acc   = r_acc;
    w_mean  = r_mean;
    w_valid = r_valid;
    if (!swiptAlive) begin
      w_state = S_IDLE;
      w_valid = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_BLIND: begin
          if (r_blind == '0) begin
            w_state = S_ACCUM;
            w_win   = WW'(WIN_CYCLES - 1);
            w_idx   = '0;
            w_peak  = '0;
            w_acc   = '0;
          end else begin
            w_blind = r_blind - BW'(1);
          end
        end
        S_ACCUM: begin
          if (r_win != '0) begin
            w_peak = w_pk;
            w_win  = r_win - WW'(1);
          end else begin
            w_acc  = r_acc + {{LW{1'b0}}, w_pk};
            w_peak = '0;
            w_win  = WW'(WIN_CYCLES - 1);
            w_idx  = r_idx + LW'(1);
            if (r_idx == LW'(NWIN - 1))
              w_state = S_UPDATE;
          end
        end
        S_UPDATE: begin
          w_mean  = r_acc[AW-1:LW];
          w_valid = 1'b1;
          w_state = S_IDLE;
        end
        default: w_state = S_IDLE;
      endcase
      // A start always (re)arms; an UPDATE on the same edge still lands.
      if (start) begin
        w_state = S_BLIND;
        w_blind = BW'(BLIND_CYCLES - 1);
        w_valid = 1'b0;
        w_peak  = '0;
        w_acc   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_blind <= '0;
      r_win   <= '0;
      r_idx   <= '0;
      r_peak  <= '0;
      r_acc   <= '0;
      r_mean  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state;
      r_blind <= w_blind;
      r_win   <= w_win;
      r_idx   <= w_idx;
      r_peak  <= w_peak;
      r_acc   <= w_acc;
      r_mean  <= w_mean;
      r_valid <= w_valid;
    end
  end

  assign mean_def   = r_mean;
  assign mean_valid = r_valid;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_adc_mean_reference.sv
// Directed bench for adc_mean_reference with short blind/window settings.
module tb_adc_mean_reference;

  logic        clk = 1'b0;
  logic        nrst;
  logic        swiptAlive;
  logic        start;
  logic [11:0] ADC;
  logic [11:0] mean_def;
  logic        mean_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int mode     = 0;
  logic [11:0] cv = '0;
  int vbad     = 0;
  int lat;

  always #5 clk = ~clk;

  adc_mean_reference #(
    .ADC_W       (12),
    .MID         (12'h800),
    .BLIND_CYCLES(4),
    .WIN_CYCLES  (8),
    .LOG2_NWIN   (2)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .swiptAlive(swiptAlive),
    .start     (start),
    .ADC       (ADC),
    .mean_def  (mean_def),
    .mean_valid(mean_valid),
    .busy      (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ADC for edge k after the start edge: 1..4 blind, 5..36 accumulate.
  function automatic logic [11:0] adc_for(input int k);
    int s;
    int w;
    if (mode == 0) return cv;
    if (k <= 4) return 12'h7FF;
    if (k > 36) return 12'h000;
    s = k - 5;
    w = s / 8;
    if ((s % 8) == 3) return 12'(256 * (w + 1));
    return 12'h050;
  endfunction

  task automatic measure(output int l);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    l = 0;
    for (int k = 1; k <= 200; k++) begin
      ADC = adc_for(k);
      @(negedge clk);
      if (busy && mean_valid) vbad++;
      if (!busy) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    nrst = 1'b0;
    swiptAlive = 1'b1;
    start = 1'b0;
    ADC = '0;
    cycles(3);
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_mean", 32'(mean_def), 32'h0);
    chk("rst_valid", 32'(mean_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    cycles(100);
    chk("idle_mean", 32'(mean_def), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    mode = 0; cv = 12'h300;
    measure(lat);
    chk("const_lat", 32'(lat), 32'd37);
    chk("const_valid", 32'(mean_valid), 32'h1);
    chk("const_mean", 32'(mean_def), 32'h300);

    cv = 12'hC00;
    measure(lat);
    chk("fold_lat", 32'(lat), 32'd37);
    chk("fold_mean", 32'(mean_def), 32'h3FF);

    cv = 12'h800;
    measure(lat);
    chk("fold_mid", 32'(mean_def), 32'h7FF);

    mode = 1;
    measure(lat);
    chk("avg_lat", 32'(lat), 32'd37);
    chk("avg_mean", 32'(mean_def), 32'h280);
    chk("avg_valid", 32'(mean_valid), 32'h1);

    mode = 0; cv = 12'h7F0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      ADC = cv;
      @(negedge clk);
    end
    chk("rs_busy", 32'(busy), 32'h1);
    chk("rs_valid0", 32'(mean_valid), 32'h0);
    cv = 12'h123;
    vbad = 0;
    measure(lat);
    chk("rs_lat", 32'(lat), 32'd37);
    chk("rs_vhold", 32'(vbad), 32'd0);
    chk("rs_mean", 32'(mean_def), 32'h123);

    cv = 12'h300;
    measure(lat);
    chk("pre_abort", 32'(mean_def), 32'h300);
    cv = 12'h555;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      ADC = cv;
      @(negedge clk);
    end
    swiptAlive = 1'b0;
    @(negedge clk);
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_valid", 32'(mean_valid), 32'h0);
    chk("ab_mean", 32'(mean_def), 32'h300);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles(50);
    chk("ab_st_busy", 32'(busy), 32'h0);
    chk("ab_st_mean", 32'(mean_def), 32'h300);
    swiptAlive = 1'b1;
    cycles(5);
    chk("ab_re_busy", 32'(busy), 32'h0);
    chk("ab_re_valid", 32'(mean_valid), 32'h0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles(20);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    chk("mrst_mean", 32'(mean_def), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_valid", 32'(mean_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
